demux_rr_sched: RTL and testbench

Round-robin scheduler that sequences a 1-to-4 demultiplexer path. A single input word stream is distributed across four sink channels. The block holds one word in a buffer register and picks the destination channel from a rotating pointer and a per-channel enable mask. It drives the 2-bit demux select and a one-hot valid, and each sink applies its own ready backpressure.

---
 rtl/demux_rr_sched_if.sv | 42 ++++
 rtl/demux_rr_sched.sv | 82 ++++++++
 tb/tb_demux_rr_sched.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_rr_sched_if.sv
// Handshake bundle between the upstream word source, the scheduler
// and the four demultiplexed sink channels.
interface demux_rr_sched_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [3:0]       en;
  logic [3:0]       out_ready;
  logic [3:0]       out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       sel;
  logic             busy;
  logic [7:0]       deliv_cnt;

  modport master (
    output in_valid,
    output in_data,
    output en,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  sel,
    input  busy,
    input  deliv_cnt
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  en,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output sel,
    output busy,
    output deliv_cnt
  );
endinterface

// File: rtl/demux_rr_sched.sv
// Round-robin scheduler for a 1-to-4 demux: one buffered word,
// rotating start pointer, enable-masked channel pick.
module demux_rr_sched #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  demux_rr_sched_if.slave bus
);
  localparam logic [1:0] EMPTY   = 2'd0;
  localparam logic [1:0] PRESENT = 2'd1;
  localparam logic [1:0] STALL   = 2'd2;

  logic [1:0]       state;
  logic [1:0]       ptr;
  logic [1:0]       sel;
  logic [WIDTH-1:0] word_q;
  logic [7:0]       cnt;

  logic       fire;
  logic       rdy;
  logic       accept;
  logic [1:0] start;
  logic [1:0] idx;
  logic [1:0] pick;
  logic       found;

  // Search from the pointer when idle or stalled, else just past sel;
  // descending loop leaves the nearest enabled channel in pick.
  always_comb begin
    fire   = (state == PRESENT) && bus.out_ready[sel];
    rdy    = (state == EMPTY) || fire;
    accept = bus.in_valid && rdy && rst_n;
    start  = (state == PRESENT) ? sel + 2'd1 : ptr;
    found  = 1'b0;
    pick   = start;
    idx    = start;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (bus.en[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      ptr    <= 2'd0;
      sel    <= 2'd0;
      word_q <= '0;
      cnt    <= 8'd0;
    end else begin
      if (accept) begin
        word_q <= bus.in_data;
        if (found) begin
          sel   <= pick;
          state <= PRESENT;
        end else begin
          state <= STALL;
        end
      end else if (fire) begin
        state <= EMPTY;
      end else if (state == STALL && found) begin
        sel   <= pick;
        state <= PRESENT;
      end
      if (fire) begin
        ptr <= sel + 2'd1;
        cnt <= cnt + 8'd1;
      end
    end
  end

  assign bus.in_ready  = rdy && rst_n;
  assign bus.out_valid = (state == PRESENT) ? (4'b0001 << sel) : 4'b0000;
  assign bus.out_data  = (state == PRESENT) ? word_q : '0;
  assign bus.sel       = sel;
  assign bus.busy      = (state != EMPTY);
  assign bus.deliv_cnt = cnt;
endmodule

// File: tb/tb_demux_rr_sched.sv
// Bench for demux_rr_sched: directed vector table, async reset
// sequence and a randomized run against a queue-level model.
module tb_demux_rr_sched;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  demux_rr_sched_if #(.WIDTH(8)) bus ();

  demux_rr_sched #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    bit         rst;
    logic       iv;
    logic [7:0] d;
    logic [3:0] en;
    logic [3:0] ordy;
    logic [3:0] ov;
    logic [7:0] od;
    logic [1:0] sel;
    logic       ir;
    logic       busy;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(bit r, logic iv, logic [7:0] d,
                              logic [3:0] en, logic [3:0] ordy,
                              logic [3:0] ov, logic [7:0] od,
                              logic [1:0] sel, logic ir, logic busy,
                              logic [7:0] cnt);
    vec_t v;
    v.rst = r; v.iv = iv; v.d = d; v.en = en; v.ordy = ordy;
    v.ov = ov; v.od = od; v.sel = sel; v.ir = ir; v.busy = busy;
    v.cnt = cnt;
    return v;
  endfunction

  task automatic drive(logic iv, logic [7:0] d, logic [3:0] en,
                       logic [3:0] ordy);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.en        = en;
    bus.out_ready = ordy;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 4'h0, 4'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Model: a single buffered word, whether it is being offered, where,
  // the round-robin pointer and the delivery count.
  bit         m_busy, m_pres;
  logic [7:0] m_data, m_cnt;
  int         m_sel, m_ptr;

  function automatic int first_en(int s, logic [3:0] e);
    for (int i = 0; i < 4; i++)
      if (e[(s + i) % 4]) return (s + i) % 4;
    return -1;
  endfunction

  task automatic model_step();
    bit f, a;
    int k;
    f = m_pres && bus.out_ready[m_sel];
    a = bus.in_valid && (!m_busy || f);
    if (f) begin
      m_cnt = m_cnt + 8'd1;
      m_ptr = (m_sel + 1) % 4;
    end
    if (a) begin
      m_data = bus.in_data;
      m_busy = 1;
      k = first_en(m_ptr, bus.en);
      m_pres = (k >= 0);
      if (k >= 0) m_sel = k;
    end else if (f) begin
      m_busy = 0;
      m_pres = 0;
    end else if (m_busy && !m_pres) begin
      k = first_en(m_ptr, bus.en);
      if (k >= 0) begin
        m_sel = k;
        m_pres = 1;
      end
    end
  endtask

  initial begin
    vec_t v;
    logic [3:0] ov_exp;
    logic       ir_exp;

    // reset with random inputs
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 4'h0, 4'h0);
    #1 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 8'($urandom), 4'($urandom), 4'($urandom));
      @(negedge clk);
      chk("rst_ov", bus.out_valid, 0);
      chk("rst_ir", bus.in_ready, 0);
      chk("rst_sel", bus.sel, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_cnt", bus.deliv_cnt, 0);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 4'hF, 4'hF);
    @(negedge clk);
    chk("rel_ir", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // full-rate round robin
    tbl.push_back(mk(1, 1, 8'hA0, 4'hF, 4'hF, 4'h0, 8'h00, 0, 1, 0, 0));
    for (int i = 1; i < 8; i++)
      tbl.push_back(mk(0, 1, 8'(8'hA0 + i), 4'hF, 4'hF,
                       4'(1 << ((i - 1) % 4)), 8'(8'hA0 + i - 1),
                       2'((i - 1) % 4), 1, 1, 8'(i - 1)));
    tbl.push_back(mk(0, 0, 8'h00, 4'hF, 4'hF, 4'h8, 8'hA7, 3, 1, 1, 7));
    tbl.push_back(mk(0, 0, 8'h00, 4'hF, 4'hF, 4'h0, 8'h00, 3, 1, 0, 8));
    // skipping disabled channels
    tbl.push_back(mk(1, 1, 8'h10, 4'hA, 4'hF, 4'h0, 8'h00, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h11, 4'hA, 4'hF, 4'h2, 8'h10, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 8'h12, 4'hA, 4'hF, 4'h8, 8'h11, 3, 1, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 4'hA, 4'hF, 4'h2, 8'h12, 1, 1, 1, 2));
    tbl.push_back(mk(0, 0, 8'h00, 4'hA, 4'hF, 4'h0, 8'h00, 1, 1, 0, 3));
    // backpressure on channel 1
    tbl.push_back(mk(1, 1, 8'h44, 4'hF, 4'hF, 4'h0, 8'h00, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h55, 4'hF, 4'hF, 4'h1, 8'h44, 0, 1, 1, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, 8'h66, 4'hF, 4'hD, 4'h2, 8'h55, 1, 0, 1, 1));
    tbl.push_back(mk(0, 1, 8'h66, 4'hF, 4'hF, 4'h2, 8'h55, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 4'hF, 4'hF, 4'h4, 8'h66, 2, 1, 1, 2));
    tbl.push_back(mk(0, 0, 8'h00, 4'hF, 4'hF, 4'h0, 8'h00, 2, 1, 0, 3));
    // stall, late enable, enable drop while presenting, wrap 3->0
    tbl.push_back(mk(1, 1, 8'h77, 4'h0, 4'hF, 4'h0, 8'h00, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h78, 4'h0, 4'hF, 4'h0, 8'h00, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 4'h4, 4'hF, 4'h0, 8'h00, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'h88, 4'h0, 4'h0, 4'h4, 8'h77, 2, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 4'h0, 4'hF, 4'h4, 8'h77, 2, 1, 1, 0));
    tbl.push_back(mk(0, 1, 8'h99, 4'hF, 4'hF, 4'h0, 8'h00, 2, 1, 0, 1));
    tbl.push_back(mk(0, 1, 8'h9A, 4'hF, 4'hF, 4'h8, 8'h99, 3, 1, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 4'hF, 4'hF, 4'h1, 8'h9A, 0, 1, 1, 2));
    tbl.push_back(mk(0, 0, 8'h00, 4'hF, 4'hF, 4'h0, 8'h00, 0, 1, 0, 3));

    foreach (tbl[i]) begin
      v = tbl[i];
      if (v.rst) do_reset();
      drive(v.iv, v.d, v.en, v.ordy);
      @(negedge clk);
      chk($sformatf("vec%0d ov", i), bus.out_valid, v.ov);
      chk($sformatf("vec%0d sel", i), bus.sel, v.sel);
      chk($sformatf("vec%0d ir", i), bus.in_ready, v.ir);
      chk($sformatf("vec%0d busy", i), bus.busy, v.busy);
      chk($sformatf("vec%0d cnt", i), bus.deliv_cnt, v.cnt);
      if (v.ov != 0 || !v.busy)
        chk($sformatf("vec%0d od", i), bus.out_data, v.od);
      @(posedge clk);
      #1;
    end

    // async reset while presenting on channel 1
    do_reset();
    drive(1'b1, 8'h31, 4'hF, 4'hF);
    @(posedge clk);
    #1 drive(1'b1, 8'h32, 4'hF, 4'hF);
    @(negedge clk);
    chk("ar_ov0", bus.out_valid, 4'h1);
    @(posedge clk);
    #1 drive(1'b0, 8'h00, 4'hF, 4'h0);
    @(negedge clk);
    chk("ar_ov1", bus.out_valid, 4'h2);
    chk("ar_od1", bus.out_data, 8'h32);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ov", bus.out_valid, 0);
    chk("ar_busy", bus.busy, 0);
    chk("ar_cnt", bus.deliv_cnt, 0);
    chk("ar_ir", bus.in_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b1, 8'h33, 4'hF, 4'hF);
    @(negedge clk);
    chk("ar_ir2", bus.in_ready, 1);
    @(posedge clk);
    #1 drive(1'b0, 8'h00, 4'hF, 4'hF);
    @(negedge clk);
    chk("ar_ov2", bus.out_valid, 4'h1);
    chk("ar_od2", bus.out_data, 8'h33);
    @(posedge clk);
    #1;

    // randomized run against the model
    do_reset();
    m_busy = 0; m_pres = 0; m_data = 0; m_cnt = 0; m_sel = 0; m_ptr = 0;
    for (int c = 0; c < 3000; c++) begin
      drive(1'($urandom),
            8'($urandom),
            ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom),
            4'($urandom));
      @(negedge clk);
      ov_exp = m_pres ? 4'(1 << m_sel) : 4'h0;
      ir_exp = !m_busy || (m_pres && bus.out_ready[m_sel]);
      chk($sformatf("rnd%0d ov", c), bus.out_valid, ov_exp);
      chk($sformatf("rnd%0d ir", c), bus.in_ready, ir_exp);
      chk($sformatf("rnd%0d busy", c), bus.busy, m_busy);
      chk($sformatf("rnd%0d cnt", c), bus.deliv_cnt, m_cnt);
      if (m_pres) begin
        chk($sformatf("rnd%0d od", c), bus.out_data, m_data);
        chk($sformatf("rnd%0d sel", c), bus.sel, m_sel);
      end
      model_step();
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
